// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Brief    : Shared op encodings, FSM states and sizing for the HI/LO
//            multiply/divide unit. MDU_FAST_MUL_EN adds the FAST state.
// Revision : 1.0  initial release
// ============================================================================
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_ITER  = 32;
    localparam int MDU_CNT_W = $clog2(MDU_ITER);

    localparam logic [2:0] c_OP_MULT  = 3'b000;
    localparam logic [2:0] c_OP_MULTU = 3'b001;
    localparam logic [2:0] c_OP_DIV   = 3'b010;
    localparam logic [2:0] c_OP_DIVU  = 3'b011;
    localparam logic [2:0] c_OP_MTHI  = 3'b100;
    localparam logic [2:0] c_OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2
`ifdef MDU_FAST_MUL_EN
        ,
        ST_FAST = 2'd3
`endif
    } mdu_state_t;

    function automatic logic mdu_op_is_signed(input logic [2:0] op);
        return (op == c_OP_MULT) || (op == c_OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iter_core
// Brief    : One-bit-per-cycle shift-add multiply / restoring divide datapath
//            with its iteration counter. Operands are unsigned magnitudes.
// Revision : 1.0  initial release
// ============================================================================
module mdu_iter_core
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic        isDiv,
    input  logic [31:0] loadA,
    input  logic [31:0] loadB,
    output logic [63:0] acc,
    output logic        countZero
);

    // Shared accumulator: multiply keeps P[64:0]; divide keeps {rem[32:0], quot[31:0]}.
    logic [64:0]          r_acc;
    logic [31:0]          r_operandB;
    logic [MDU_CNT_W-1:0] r_count;

    logic [32:0] w_mulSum;
    logic [64:0] w_mulNext;
    logic [32:0] w_shifted;
    logic [33:0] w_trial;
    logic [64:0] w_divNext;

    always_comb begin
        w_mulSum  = r_acc[64:32] + {1'b0, r_operandB};
        w_mulNext = r_acc[0] ? {1'b0, w_mulSum, r_acc[31:1]} : {1'b0, r_acc[64:1]};
        w_shifted = {r_acc[63:32], r_acc[31]};
        w_trial   = {1'b0, w_shifted} - {2'b00, r_operandB};
        w_divNext = w_trial[33] ? {w_shifted, r_acc[30:0], 1'b0}
                                : {w_trial[32:0], r_acc[30:0], 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_operandB <= '0;
            r_count    <= '0;
        end else if (load) begin
            r_acc      <= {33'd0, loadA};
            r_operandB <= loadB;
            r_count    <= MDU_CNT_W'(MDU_ITER - 1);
        end else if (step) begin
            r_acc      <= isDiv ? w_divNext : w_mulNext;
            r_count    <= r_count - 1'b1;
        end
    end

    assign acc       = r_acc[63:0];
    assign countZero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mdu_hilo.sv
`default_nettype none
// ============================================================================
// Module   : mdu_hilo
// Brief    : EX-stage multiply/divide unit with architectural HI/LO registers.
//            Define MDU_FAST_MUL_EN for a single-cycle multiplier path.
// Revision : 1.0  initial release
// ============================================================================
module mdu_hilo
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_t r_state;
    logic       r_negQ;
    logic       r_negR;
    logic       r_isDiv;
    logic       r_divZero;

    logic        w_isSigned;
    logic        w_isMulOp;
    logic        w_isDivOp;
    logic        w_divZero;
    logic        w_load;
    logic [31:0] w_magA;
    logic [31:0] w_magB;
    logic [31:0] w_loadA;
    logic [63:0] w_acc;
    logic        w_countZero;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_resHi;
    logic [31:0] w_resLo;

    assign w_isSigned = mdu_op_is_signed(op);
    assign w_isMulOp  = (op == c_OP_MULT) || (op == c_OP_MULTU);
    assign w_isDivOp  = (op == c_OP_DIV)  || (op == c_OP_DIVU);
    assign w_divZero  = w_isDivOp && (opb == 32'd0);
    assign w_magA     = (w_isSigned && opa[31]) ? -opa : opa;
    assign w_magB     = (w_isSigned && opb[31]) ? -opb : opb;
    // Divide-by-zero parks the raw dividend in the core so SIGN can return it as HI.
    assign w_loadA    = w_divZero ? opa : w_magA;

`ifdef MDU_FAST_MUL_EN
    logic [63:0] r_fastProd;
    logic [63:0] w_extA;
    logic [63:0] w_extB;
    logic [63:0] w_fastProd;

    assign w_extA     = w_isSigned ? {{32{opa[31]}}, opa} : {32'd0, opa};
    assign w_extB     = w_isSigned ? {{32{opb[31]}}, opb} : {32'd0, opb};
    assign w_fastProd = w_extA * w_extB;
    assign w_load     = (r_state == ST_IDLE) && start && w_isDivOp;
`else
    assign w_load     = (r_state == ST_IDLE) && start && (w_isMulOp || w_isDivOp);
`endif

    mdu_iter_core u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .step      (r_state == ST_CALC),
        .isDiv     (r_isDiv),
        .loadA     (w_loadA),
        .loadB     (w_magB),
        .acc       (w_acc),
        .countZero (w_countZero)
    );

    always_comb begin
        w_prod = r_negQ ? -w_acc : w_acc;
        w_quot = r_negQ ? -w_acc[31:0] : w_acc[31:0];
        w_rem  = r_negR ? -w_acc[63:32] : w_acc[63:32];
        if (r_divZero) begin
            w_resHi = w_acc[31:0];
            w_resLo = 32'hFFFF_FFFF;
        end else if (r_isDiv) begin
            w_resHi = w_rem;
            w_resLo = w_quot;
        end else begin
            w_resHi = w_prod[63:32];
            w_resLo = w_prod[31:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_isDiv   <= 1'b0;
            r_divZero <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
`ifdef MDU_FAST_MUL_EN
            r_fastProd <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (op == c_OP_MTHI) begin
                            hi <= opa;
                        end else if (op == c_OP_MTLO) begin
                            lo <= opa;
`ifdef MDU_FAST_MUL_EN
                        end else if (w_isMulOp) begin
                            r_fastProd <= w_fastProd;
                            r_state    <= ST_FAST;
`endif
                        end else if (w_load) begin
                            r_negQ    <= w_isSigned && (opa[31] ^ opb[31]);
                            r_negR    <= w_isSigned && opa[31];
                            r_isDiv   <= w_isDivOp;
                            r_divZero <= w_divZero;
                            r_state   <= w_divZero ? ST_SIGN : ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (w_countZero) begin
                        r_state <= ST_SIGN;
                    end
                end
                ST_SIGN: begin
                    hi      <= w_resHi;
                    lo      <= w_resLo;
                    done    <= 1'b1;
                    r_state <= ST_IDLE;
                end
`ifdef MDU_FAST_MUL_EN
                ST_FAST: begin
                    hi      <= r_fastProd[63:32];
                    lo      <= r_fastProd[31:0];
                    done    <= 1'b1;
                    r_state <= ST_IDLE;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mdu_hilo.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_hilo
// Brief    : Self-checking bench for mdu_hilo against an arithmetic reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b110;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int nChecks = 0;
    int nPass   = 0;

    mdu_hilo dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .opa   (opa),
        .opb   (opb),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        assert (observed === expected) nPass++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // {HI, LO} from the architectural definition of each op.
    function automatic logic [63:0] refModel(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, q, r, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        if (o[1] && b == 32'd0) return {a, 32'hFFFF_FFFF};
        case (o)
            3'b000:  begin p = sa * sb; return p; end
            3'b001:  begin p = ua * ub; return p; end
            3'b010:  begin q = sa / sb; r = sa % sb; return {r[31:0], q[31:0]}; end
            default: begin q = ua / ub; r = ua % ub; return {r[31:0], q[31:0]}; end
        endcase
    endfunction

    function automatic int expBusy(input logic [2:0] o, input logic [31:0] b);
`ifdef MDU_FAST_MUL_EN
        if (!o[1]) return 1;
`endif
        if (o[1] && b == 32'd0) return 1;
        return 33;
    endfunction

    task automatic doOp(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit inject);
        logic [63:0] expRes;
        int busyCnt;
        int earlyDone;
        expRes    = refModel(o, a, b);
        busyCnt   = 0;
        earlyDone = 0;
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); opa = $urandom; opb = $urandom;
        while (busy === 1'b1 && busyCnt < 100) begin
            busyCnt++;
            if (done !== 1'b0) earlyDone++;
            if (inject && busyCnt == 5) begin
                start = 1'b1; op = 3'b101; opa = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " busyCycles"}, 64'(busyCnt), 64'(expBusy(o, b)));
        check({tag, " noEarlyDone"}, 64'(earlyDone), 64'd0);
        check({tag, " done"}, {63'd0, done}, 64'd1);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, expRes[63:32]});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, expRes[31:0]});
        @(negedge clk);
        check({tag, " doneOnePulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic [2:0]  rOp;
        logic [31:0] rA;
        logic [31:0] rB;
        int doneCnt;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        rst = 1'b0;

        // MTHI / MTLO / no-op: immediate write, never busy
        start = 1'b1; op = 3'b100; opa = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0;
        check("mthi hi", {32'd0, hi}, 64'h1234);
        check("mthi lo", {32'd0, lo}, 64'd0);
        check("mthi busy", {63'd0, busy}, 64'd0);
        start = 1'b1; op = 3'b101; opa = 32'hCAFE_0001;
        @(negedge clk);
        start = 1'b1; op = 3'b110; opa = 32'h5555_5555;
        check("mtlo lo", {32'd0, lo}, 64'hCAFE_0001);
        check("mtlo hi", {32'd0, hi}, 64'h1234);
        @(negedge clk);
        start = 1'b0;
        check("noop hi", {32'd0, hi}, 64'h1234);
        check("noop lo", {32'd0, lo}, 64'hCAFE_0001);
        check("noop busy", {63'd0, busy}, 64'd0);

        doOp("mult -3*7", 3'b000, 32'hFFFF_FFFD, 32'd7, 1'b0);
        doOp("multu max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        doOp("div -7/2", 3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0);
        doOp("divu 7/2", 3'b011, 32'd7, 32'd2, 1'b0);
        doOp("divu 100/0", 3'b011, 32'd100, 32'd0, 1'b0);
        doOp("div ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        doOp("div 7/-0", 3'b010, 32'hFFFF_FFF9, 32'd0, 1'b0);
        doOp("div 9/-4", 3'b010, 32'd9, 32'hFFFF_FFFC, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rOp = 3'($urandom_range(0, 3));
            rA  = $urandom;
            rB  = $urandom;
            case ($urandom_range(0, 5))
                0:       rB = 32'd0;
                1:       rB = $urandom_range(1, 15);
                2:       begin rA = 32'h8000_0000; rB = 32'hFFFF_FFFF; end
                3:       rA = $urandom_range(0, 255);
                default: ;
            endcase
            doOp("random", rOp, rA, rB, 1'b0);
        end

        // start while busy must be ignored
        doOp("mult ignore mtlo", 3'b000, 32'h0001_0003, 32'hFFFF_0007, 1'b1);

        // asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1; op = 3'b000; opa = 32'd5; opb = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort busyBefore", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort hi", {32'd0, hi}, 64'd0);
        check("abort lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0) doneCnt++;
        end
        check("abort noDone", 64'(doneCnt), 64'd0);
        check("abort idle", {63'd0, busy}, 64'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
